// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/mem/writeback sequencing.
// Optional terminal illegal-instruction trap: MULTICYCLE_CONTROL_TRAP_EN.
module multicycle_control #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [3:0] LAT    = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last;
  logic [2:0] alu_dec;
  logic       f3_bad;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (cnt_q == LAT);

  always_comb begin
    alu_dec = 3'b000;
    f3_bad  = 1'b0;
    unique case (funct3)
      3'b000:  alu_dec = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: f3_bad  = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    unique case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
    unique case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = last;
        pcwrite   = last;
        if (last) state_d = S_DECODE;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (last) state_d = S_MEMWB;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = last;
        if (last) state_d = S_FETCH;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_EXECR, S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alucontrol = alu_dec;
        state_d    = f3_bad ? S_ILLEGAL : S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = 3'b001;
        pcwrite    = zero;
        state_d    = S_FETCH;
      end
      default: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end
    endcase
    // reset cycle: no strobe fires and every select reads as zero
    if (!reset_n) begin
      pcwrite    = 1'b0;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      immsrc     = 2'b00;
      alucontrol = 3'b000;
    end
  end

`ifdef MULTICYCLE_CONTROL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal_instr = reset_n & illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (MEM_LAT 0 and 2 instances).
module tb_multicycle_control;

  logic       clk;
  logic       rst0, rst2;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero_i;
  logic       sel;

  logic pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic pcw2, adr2, mw2, irw2, rw2, ill2;
  logic [1:0] rs2, sa2, sb2, imm2;
  logic [2:0] alu2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [16:0] v;
    string       t;
  } exp_t;
  exp_t q[$];

  multicycle_control #(.MEM_LAT(0)) dut0 (
    .clk(clk), .reset_n(rst0), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero_i),
    .pcwrite(pcw0), .adrsrc(adr0), .memwrite(mw0),
    .irwrite(irw0), .regwrite(rw0), .resultsrc(rs0),
    .alusrca(sa0), .alusrcb(sb0), .immsrc(imm0),
    .alucontrol(alu0), .illegal_instr(ill0)
  );

  multicycle_control #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset_n(rst2), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero_i),
    .pcwrite(pcw2), .adrsrc(adr2), .memwrite(mw2),
    .irwrite(irw2), .regwrite(rw2), .resultsrc(rs2),
    .alusrca(sa2), .alusrcb(sb2), .immsrc(imm2),
    .alucontrol(alu2), .illegal_instr(ill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [16:0] obs0 = {pcw0, adr0, mw0, irw0, rw0,
                      rs0, sa0, sb0, imm0, alu0, ill0};
  wire [16:0] obs2 = {pcw2, adr2, mw2, irw2, rw2,
                      rs2, sa2, sb2, imm2, alu2, ill2};

  function automatic logic [16:0] v(
    int pcw, int adr, int mw, int irw, int rw,
    int rs, int sa, int sb, int imm, int alu, int ill);
    return {pcw[0], adr[0], mw[0], irw[0], rw[0],
            rs[1:0], sa[1:0], sb[1:0], imm[1:0],
            alu[2:0], ill[0]};
  endfunction

  task automatic p(input logic [16:0] x, input string t);
    exp_t e;
    e.v = x;
    e.t = t;
    q.push_back(e);
  endtask

  task automatic fetch(input int lat, input int imm);
    for (int i = 0; i < lat; i++)
      p(v(0,0,0,0,0, 2,0,2,imm,0,0), "fetch_wait");
    p(v(1,0,0,1,0, 2,0,2,imm,0,0), "fetch");
  endtask

  task automatic decode(input int imm);
    p(v(0,0,0,0,0, 0,1,1,imm,0,0), "decode");
  endtask

  task automatic aluwb(input int imm);
    p(v(0,0,0,0,1, 0,0,0,imm,0,0), "aluwb");
  endtask

  task automatic run();
    int n;
    n = q.size();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $error("FAIL expired_wait pending=%0d", q.size());
      q.delete();
    end
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    zero_i   = z;
  endtask

  task automatic rtype(input logic [2:0] f3, input logic f7,
                       input int alu, input string t);
    set_in(7'b0110011, f3, f7, 1'b0);
    fetch(0, 0);
    decode(0);
    p(v(0,0,0,0,0, 0,2,0,0,alu,0), t);
    aluwb(0);
    run();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [16:0] obs;
    if (q.size() > 0) begin
      e   = q.pop_front();
      obs = sel ? obs2 : obs0;
      n_cmp++;
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s observed=%b expected=%b", e.t, obs, e.v);
      end
    end
  end

  initial begin
    sel  = 1'b0;
    rst0 = 1'b0;
    rst2 = 1'b0;
    set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
    repeat (3) p(v(0,0,0,0,0, 0,0,0,0,0,0), "reset");
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (obs0 !== 17'd0) begin
      n_err++;
      $error("FAIL reset_state observed=%b", obs0);
    end
    rst0 = 1'b1;

    rtype(3'b000, 1'b0, 0, "add");
    rtype(3'b000, 1'b1, 1, "sub");
    rtype(3'b111, 1'b0, 2, "and");
    rtype(3'b110, 1'b0, 3, "or");

    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    fetch(0, 0);
    decode(0);
    p(v(0,0,0,0,0, 0,2,1,0,0,0), "addi_f7_ignored");
    aluwb(0);
    run();

    set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
    fetch(0, 0);
    decode(0);
    run();
    rst0 = 1'b0;
    p(v(0,0,0,0,0, 0,0,0,0,0,0), "mid_reset");
    run();
    rst0 = 1'b1;

    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    rst0 = 1'b0;
    rst2 = 1'b1;
    sel  = 1'b1;
    fetch(2, 0);
    decode(0);
    p(v(0,0,0,0,0, 0,2,1,0,0,0), "lw_memadr");
    repeat (3) p(v(0,1,0,0,0, 0,0,0,0,0,0), "lw_memread");
    p(v(0,0,0,0,1, 1,0,0,0,0,0), "lw_memwb");
    run();
    rst2 = 1'b0;
    rst0 = 1'b1;
    sel  = 1'b0;

    for (int z = 1; z >= 0; z--) begin
      set_in(7'b1100011, 3'b000, 1'b0, z[0]);
      fetch(0, 2);
      decode(2);
      p(v(z,0,0,0,0, 0,2,0,2,1,0), "beq");
      run();
    end

    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch(0, 1);
    decode(1);
    p(v(0,0,0,0,0, 0,2,1,1,0,0), "sw_memadr");
    p(v(0,1,1,0,0, 0,0,0,1,0,0), "sw_memwrite");
    run();

    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    fetch(0, 3);
    decode(3);
    p(v(1,0,0,0,0, 0,1,2,3,0,0), "jal");
    aluwb(3);
    run();

    set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
    fetch(0, 0);
    decode(0);
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    repeat (3) p(v(0,0,0,0,0, 0,0,0,0,0,1), "illegal_trap");
`else
    p(v(0,0,0,0,0, 0,0,0,0,0,0), "illegal_nop");
    fetch(0, 0);
`endif
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the primitive RISC-V datapath.
- It drives the ALU's alucontrol input and consumes the ALU's zero flag, which makes it the initiator end of the ALU control interface.
- It sequences instruction fetch, decode, execute, memory access and writeback, and generates all datapath mux selects and write strobes.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
MEM_LAT, 0, extra wait cycles added to every memory-access state (FETCH, MEMREAD, MEMWRITE); legal range 0..15.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
op  input  7  instruction opcode, instr[6:0]
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
pcwrite  output  1  PC register write enable
adrsrc  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  data memory write strobe
irwrite  output  1  instruction register / oldPC write enable
regwrite  output  1  register file write enable
resultsrc  output  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result
alusrca  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
alusrcb  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
immsrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
alucontrol  output  3  000 = add, 001 = sub, 010 = and, 011 = or
illegal_instr  output  1  unsupported opcode/funct3 detected (see Optional Feature)

Behaviour:
- Reset (reset_n low at clk edge):
  - state <= FETCH, wait counter <= 0.
  - While reset_n is low, pcwrite, memwrite, irwrite, regwrite and illegal_instr are forced to 0.
  - All selects are 0; alucontrol = 000.
  - The first cycle after release is FETCH, counter 0.
- Reset asserted mid-instruction abandons it; no strobe fires in the reset cycle.
- immsrc is combinational from op: lw/I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- ALU decode (execute states for R/I-ALU only):
  - funct3 000 -> add, or sub only when op = 0110011 and funct7b5 = 1.
  - funct3 110 -> or; funct3 111 -> and.
  - Any other funct3 is illegal.
- States (outputs not listed are 0 / 00):
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10. irwrite=1 and pcwrite=1 only in the last cycle. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01, add (precompute branch target). Next by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - other -> ILLEGAL
  - MEMADR: alusrca=10, alusrcb=01, add. Next: MEMREAD if lw, else MEMWRITE.
  - MEMREAD: adrsrc=1, resultsrc=00. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next: FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 only in the last cycle. Next: FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, decoded op. Next: ALUWB, or ILLEGAL on bad funct3.
  - EXECUTEI: alusrca=10, alusrcb=01, decoded op. funct7b5 is ignored, so 000 is always add. Next: ALUWB, or ILLEGAL on bad funct3.
  - ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1. Next: ALUWB.
  - BEQ: alusrca=10, alusrcb=00, sub, resultsrc=00, pcwrite=zero. Next: FETCH.
  - ILLEGAL: see Optional Feature.
- Wait counter (FETCH, MEMREAD, MEMWRITE):
  - The state holds for MEM_LAT+1 cycles; the counter increments each cycle and clears on exit.
  - Outputs are stable for the whole dwell; strobes fire only when counter == MEM_LAT.
  - With MEM_LAT=0, each state lasts 1 cycle.
- Cycles per instruction at MEM_LAT=0: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Strobes are Moore outputs of the registered state. zero is sampled combinationally in BEQ.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_TRAP_EN.
- Defined:
  - ILLEGAL is terminal. illegal_instr = 1 and all strobes = 0 until reset.
  - illegal_instr is registered; it rises in the first ILLEGAL cycle.
- Undefined:
  - ILLEGAL lasts 1 cycle with no strobes, then goes to FETCH (the instruction acts as a NOP).
  - illegal_instr is tied to 0.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with op=0110011 -> all strobes 0, alucontrol=000; first cycle after release shows irwrite=1, pcwrite=1, alusrcb=10.
- add/sub/and/or R-type (funct3 000/000/111/110, funct7b5 0/1/0/0) -> EXECUTER alucontrol 000/001/010/011; regwrite=1 exactly once, in cycle 4.
- lw with MEM_LAT=2 -> FETCH 3 cycles (irwrite only in the 3rd), MEMREAD 3 cycles, MEMWB resultsrc=01, regwrite=1; total 9 cycles.
- beq with zero=1, then with zero=0 -> pcwrite=1 in the BEQ cycle only when zero=1; alucontrol=001; 3 cycles each.
- sw then jal -> memwrite=1 once with adrsrc=1; jal gives pcwrite=1 in the JAL cycle, then regwrite in ALUWB, immsrc=11.
- op=1111111, with and without MULTICYCLE_CONTROL_TRAP_EN -> defined: illegal_instr=1 stays high and no strobes; undefined: returns to FETCH after 1 cycle with illegal_instr=0.
